// File: rtl/avalon_pwm_guard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_guard_pkg
// Brief    : Shared register map, bit positions and pair FSM state encoding
//            for the Avalon PWM shoot-through guard.
// Revision : 1.0 - initial release
// ============================================================================
package pwm_guard_pkg;

  localparam int C_NUM_PAIRS = 4;

  // Register addresses
  localparam logic [1:0] C_ADDR_CTRL      = 2'd0;
  localparam logic [1:0] C_ADDR_MIN_DT    = 2'd1;
  localparam logic [1:0] C_ADDR_STATUS    = 2'd2;
  localparam logic [1:0] C_ADDR_FAULT_CNT = 2'd3;

  // CTRL bit positions
  localparam int C_CTRL_ENABLE    = 0;
  localparam int C_CTRL_FAULT_CLR = 1;
  localparam int C_CTRL_IRQ_EN    = 2;

  // STATUS bit positions
  localparam int C_STAT_LATCHED = 0;
  localparam int C_STAT_SYNC    = 1;
  localparam int C_STAT_ST_LSB  = 4;

  // Pair request codes {low side, high side}
  localparam logic [1:0] C_REQ_HI   = 2'b01;
  localparam logic [1:0] C_REQ_LO   = 2'b10;
  localparam logic [1:0] C_REQ_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_DEAD = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } pair_state_e;

endpackage
`default_nettype wire

// File: rtl/avalon_pwm_guard_pair.sv
`default_nettype none
// ============================================================================
// Module   : pwm_guard_pair
// Brief    : One half-bridge pair: DEAD/HI/LO FSM with a saturating dead-time
//            counter and registered gate drives.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_guard_pair
  import pwm_guard_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        i_force_dead,
  input  logic [1:0]  i_req,
  input  logic [15:0] i_min_dt,
  output logic        o_gate_hi,
  output logic        o_gate_lo,
  output logic        o_conflict
);

  pair_state_e r_state;
  logic [15:0] r_cnt;
  logic        w_dt_ok;

  // Dead time is met once the counter has reached the currently programmed gap
  assign w_dt_ok    = (r_cnt >= i_min_dt);
  assign o_conflict = (i_req == C_REQ_BOTH);

  // Pair FSM: state, dead counter and gate drives all advance together
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state   <= ST_DEAD;
      r_cnt     <= '0;
      o_gate_hi <= 1'b0;
      o_gate_lo <= 1'b0;
    end else if (i_force_dead || (i_req == C_REQ_BOTH)) begin
      r_state   <= ST_DEAD;
      r_cnt     <= '0;
      o_gate_hi <= 1'b0;
      o_gate_lo <= 1'b0;
    end else begin
      case (r_state)
        ST_HI: begin
          if (i_req != C_REQ_HI) begin
            r_state   <= ST_DEAD;
            r_cnt     <= '0;
            o_gate_hi <= 1'b0;
          end
        end
        ST_LO: begin
          if (i_req != C_REQ_LO) begin
            r_state   <= ST_DEAD;
            r_cnt     <= '0;
            o_gate_lo <= 1'b0;
          end
        end
        default: begin
          o_gate_hi <= 1'b0;
          o_gate_lo <= 1'b0;
          if ((i_req == C_REQ_HI) && w_dt_ok) begin
            r_state   <= ST_HI;
            o_gate_hi <= 1'b1;
          end else if ((i_req == C_REQ_LO) && w_dt_ok) begin
            r_state   <= ST_LO;
            o_gate_lo <= 1'b1;
          end else begin
            r_state <= ST_DEAD;
            if (r_cnt != 16'hFFFF) begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/avalon_pwm_guard.sv
`default_nettype none
// ============================================================================
// Module   : avalon_pwm_guard
// Brief    : Avalon-MM register front end, fault synchroniser/latch and four
//            dead-time protected PWM pairs.
// Revision : 1.0 - initial release
// ============================================================================
module avalon_pwm_guard
  import pwm_guard_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic        cs,
  input  logic        wr_n,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  input  logic [7:0]  pwm_in,
  input  logic        fault_n,
  output logic [7:0]  gate_out,
  output logic        irq
);

  logic        r_enable;
  logic        r_irq_en;
  logic [15:0] r_min_dt;
  logic [3:0]  r_st_flags;
  logic        r_fault_latched;
  logic [15:0] r_fault_cnt;
  logic        r_fault_meta;
  logic        r_fault_sync;

  logic        w_wr;
  logic        w_fault_clr;
  logic        w_force_dead;
  logic        w_latch_nxt;
  logic [3:0]  w_st_clr;
  logic [3:0]  w_conflict;
  logic        w_unused_bits;

  assign w_wr          = cs & ~wr_n;
  assign w_fault_clr   = w_wr && (addr == C_ADDR_CTRL) && wr_data[C_CTRL_FAULT_CLR];
  assign w_st_clr      = (w_wr && (addr == C_ADDR_STATUS)) ? wr_data[C_STAT_ST_LSB +: 4] : 4'd0;
  assign w_force_dead  = ~r_enable | r_fault_latched;
  // An active synchronised fault always beats a same-cycle clear
  assign w_latch_nxt   = r_fault_sync | (r_fault_latched & ~w_fault_clr);
  assign irq           = r_fault_latched & r_irq_en;
  assign w_unused_bits = ^wr_data[31:16];

  // Two-flop fault synchroniser; inversion is taken ahead of the first flop so
  // the cleared (reset) state of both flops means "no fault".
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_fault_meta <= 1'b0;
      r_fault_sync <= 1'b0;
    end else begin
      r_fault_meta <= ~fault_n;
      r_fault_sync <= r_fault_meta;
    end
  end

  // Register file, fault latch, fault counter and shoot-through flags
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_enable        <= 1'b0;
      r_irq_en        <= 1'b0;
      r_min_dt        <= '0;
      r_st_flags      <= '0;
      r_fault_latched <= 1'b0;
      r_fault_cnt     <= '0;
    end else begin
      if (w_wr && (addr == C_ADDR_CTRL)) begin
        r_enable <= wr_data[C_CTRL_ENABLE];
        r_irq_en <= wr_data[C_CTRL_IRQ_EN];
      end
      if (w_wr && (addr == C_ADDR_MIN_DT)) begin
        r_min_dt <= wr_data[15:0];
      end
      // A fresh conflict overrides a clear of the same flag
      r_st_flags      <= (r_st_flags & ~w_st_clr) | w_conflict;
      r_fault_latched <= w_latch_nxt;
      if (!r_fault_latched && w_latch_nxt && (r_fault_cnt != 16'hFFFF)) begin
        r_fault_cnt <= r_fault_cnt + 16'd1;
      end
    end
  end

  // Combinational read mux; unused bits read as zero
  always_comb begin
    rd_data = '0;
    case (addr)
      C_ADDR_CTRL: begin
        rd_data[C_CTRL_ENABLE] = r_enable;
        rd_data[C_CTRL_IRQ_EN] = r_irq_en;
      end
      C_ADDR_MIN_DT:    rd_data[15:0] = r_min_dt;
      C_ADDR_STATUS: begin
        rd_data[C_STAT_LATCHED]         = r_fault_latched;
        rd_data[C_STAT_SYNC]            = r_fault_sync;
        rd_data[C_STAT_ST_LSB +: 4]     = r_st_flags;
      end
      C_ADDR_FAULT_CNT: rd_data[15:0] = r_fault_cnt;
      default:          rd_data = '0;
    endcase
  end

  genvar k;
  generate
    for (k = 0; k < C_NUM_PAIRS; k++) begin : g_pair
      pwm_guard_pair u_pair (
        .clk          (clk),
        .clr_n        (clr_n),
        .i_force_dead (w_force_dead),
        .i_req        (pwm_in[2*k +: 2]),
        .i_min_dt     (r_min_dt),
        .o_gate_hi    (gate_out[2*k]),
        .o_gate_lo    (gate_out[2*k+1]),
        .o_conflict   (w_conflict[k])
      );
    end
  endgenerate

endmodule
`default_nettype wire
